// File: rtl/zeroriscy_tracer_defines.sv
// rtl/zeroriscy_tracer_defines.sv - tracer instruction classes, masks and trace record type
package zeroriscy_tracer_defines;

  localparam int TRC_SEQ_W = 16;

  typedef enum logic [2:0] {
    TRC_ALU       = 3'd0,
    TRC_MULDIV    = 3'd1,
    TRC_BRANCH    = 3'd2,
    TRC_JUMP      = 3'd3,
    TRC_LOAD      = 3'd4,
    TRC_STORE     = 3'd5,
    TRC_CSR       = 3'd6,
    TRC_SYS_OTHER = 3'd7
  } trc_class_e;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          instr;
    trc_class_e           cls;
    logic [4:0]           rd_addr;
    logic [31:0]          rd_wdata;
    logic [TRC_SEQ_W-1:0] seq;
  } trace_rec_t;

  // An instruction matches a pattern when (instr & mask) == match.
  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
  } instr_pat_t;

  localparam instr_pat_t INSTR_LUI    = '{32'h0000_007F, 32'h0000_0037};
  localparam instr_pat_t INSTR_AUIPC  = '{32'h0000_007F, 32'h0000_0017};
  localparam instr_pat_t INSTR_JAL    = '{32'h0000_007F, 32'h0000_006F};
  localparam instr_pat_t INSTR_JALR   = '{32'h0000_707F, 32'h0000_0067};
  localparam instr_pat_t INSTR_BRANCH = '{32'h0000_007F, 32'h0000_0063};
  localparam instr_pat_t INSTR_OPIMM  = '{32'h0000_007F, 32'h0000_0013};
  localparam instr_pat_t INSTR_OP     = '{32'h0000_007F, 32'h0000_0033};
  localparam instr_pat_t INSTR_MULDIV = '{32'hFE00_007F, 32'h0200_0033};
  localparam instr_pat_t INSTR_LOAD   = '{32'h0000_007F, 32'h0000_0003};
  localparam instr_pat_t INSTR_STORE  = '{32'h0000_007F, 32'h0000_0023};
  localparam instr_pat_t INSTR_SYSTEM = '{32'h0000_007F, 32'h0000_0073};

  function automatic logic instr_match(input logic [31:0] instr, input instr_pat_t pat);
    return (instr & pat.mask) == pat.match;
  endfunction

  // MULDIV shares the OP opcode, so it must win before the ALU check.
  function automatic trc_class_e trc_classify(input logic [31:0] instr);
    if (instr_match(instr, INSTR_MULDIV)) return TRC_MULDIV;
    if (instr_match(instr, INSTR_OP) || instr_match(instr, INSTR_OPIMM) ||
        instr_match(instr, INSTR_LUI) || instr_match(instr, INSTR_AUIPC)) return TRC_ALU;
    if (instr_match(instr, INSTR_BRANCH)) return TRC_BRANCH;
    if (instr_match(instr, INSTR_JAL) || instr_match(instr, INSTR_JALR)) return TRC_JUMP;
    if (instr_match(instr, INSTR_LOAD)) return TRC_LOAD;
    if (instr_match(instr, INSTR_STORE)) return TRC_STORE;
    if (instr_match(instr, INSTR_SYSTEM) && instr[14:12] != 3'b000) return TRC_CSR;
    return TRC_SYS_OTHER;
  endfunction

endpackage

// File: rtl/zeroriscy_trace_fifo.sv
// rtl/zeroriscy_trace_fifo.sv - synchronous FIFO of trace records with hold-last output
module zeroriscy_trace_fifo
  import zeroriscy_tracer_defines::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  trace_rec_t       push_data,
  input  logic             pop,
  output trace_rec_t       pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  trace_rec_t       mem [DEPTH];
  trace_rec_t       hold;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = count == '0;
  assign full    = count == CNT_W'(DEPTH);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  // Once drained, the output keeps presenting the last record popped.
  assign pop_data = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        hold   <= mem[rd_ptr];
      end
      if (do_push && !do_pop) count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/zeroriscy_trace_capture.sv
// rtl/zeroriscy_trace_capture.sv - retire-point trace capture: classify, sequence, buffer, count drops
module zeroriscy_trace_capture
  import zeroriscy_tracer_defines::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid_i,
  input  logic [31:0]      retire_pc_i,
  input  logic [31:0]      retire_instr_i,
  input  logic             retire_rd_we_i,
  input  logic [4:0]       retire_rd_addr_i,
  input  logic [31:0]      retire_rd_wdata_i,
  output logic             trc_valid_o,
  input  logic             trc_ready_i,
  output logic [31:0]      trc_pc_o,
  output logic [31:0]      trc_instr_o,
  output logic [2:0]       trc_class_o,
  output logic [4:0]       trc_rd_addr_o,
  output logic [31:0]      trc_rd_wdata_o,
  output logic [SEQ_W-1:0] trc_seq_o,
  output logic             overflow_o,
  output logic [SEQ_W-1:0] drop_cnt_o,
  input  logic             clr_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  trace_rec_t       wr_rec;
  trace_rec_t       rd_rec;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic             drop;
  logic [SEQ_W-1:0] seq_q;

  assign pop  = !fifo_empty && trc_ready_i;
  assign push = retire_valid_i && (!fifo_full || pop);
  assign drop = retire_valid_i && !pop && (fifo_count == CNT_W'(DEPTH));

  always_comb begin
    wr_rec          = '0;
    wr_rec.pc       = retire_pc_i;
    wr_rec.instr    = retire_instr_i;
    wr_rec.cls      = trc_classify(retire_instr_i);
    wr_rec.rd_addr  = retire_rd_we_i ? retire_rd_addr_i : 5'd0;
    wr_rec.rd_wdata = retire_rd_we_i ? retire_rd_wdata_i : 32'd0;
    wr_rec.seq      = TRC_SEQ_W'(seq_q);
  end

  zeroriscy_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(wr_rec),
    .pop      (pop),
    .pop_data (rd_rec),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign trc_valid_o    = !fifo_empty;
  assign trc_pc_o       = rd_rec.pc;
  assign trc_instr_o    = rd_rec.instr;
  assign trc_class_o    = rd_rec.cls;
  assign trc_rd_addr_o  = rd_rec.rd_addr;
  assign trc_rd_wdata_o = rd_rec.rd_wdata;
  assign trc_seq_o      = SEQ_W'(rd_rec.seq);

  // Sequence advances on every retire, dropped or not, so consumers see gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q      <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (retire_valid_i) seq_q <= seq_q + SEQ_W'(1);
      if (clr_i) begin
        overflow_o <= drop;
        drop_cnt_o <= drop ? SEQ_W'(1) : '0;
      end else if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + SEQ_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_trace_capture.sv
// tb/tb_zeroriscy_trace_capture.sv - randomized self-checking bench for zeroriscy_trace_capture
module tb_zeroriscy_trace_capture;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic        retire_rd_we;
  logic [4:0]  retire_rd_addr;
  logic [31:0] retire_rd_wdata;
  logic        trc_ready;
  logic        clr;
  logic        trc_valid;
  logic [31:0] trc_pc;
  logic [31:0] trc_instr;
  logic [2:0]  trc_class;
  logic [4:0]  trc_rd_addr;
  logic [31:0] trc_rd_wdata;
  logic [15:0] trc_seq;
  logic        overflow;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  zeroriscy_trace_capture #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .retire_valid_i   (retire_valid),
    .retire_pc_i      (retire_pc),
    .retire_instr_i   (retire_instr),
    .retire_rd_we_i   (retire_rd_we),
    .retire_rd_addr_i (retire_rd_addr),
    .retire_rd_wdata_i(retire_rd_wdata),
    .trc_valid_o      (trc_valid),
    .trc_ready_i      (trc_ready),
    .trc_pc_o         (trc_pc),
    .trc_instr_o      (trc_instr),
    .trc_class_o      (trc_class),
    .trc_rd_addr_o    (trc_rd_addr),
    .trc_rd_wdata_o   (trc_rd_wdata),
    .trc_seq_o        (trc_seq),
    .overflow_o       (overflow),
    .drop_cnt_o       (drop_cnt),
    .clr_i            (clr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [15:0] seq;
  } rec_t;

  rec_t        q[$];
  rec_t        last;
  logic [15:0] m_seq;
  logic        m_ovf;
  int          m_drops;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_class(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    case (op)
      7'h33:               return (w[31:25] == 7'h01) ? 3'd1 : 3'd0;
      7'h13, 7'h37, 7'h17: return 3'd0;
      7'h63:               return 3'd2;
      7'h6F:               return 3'd3;
      7'h67:               return (f3 == 3'd0) ? 3'd3 : 3'd7;
      7'h03:               return 3'd4;
      7'h23:               return 3'd5;
      7'h73:               return (f3 != 3'd0) ? 3'd6 : 3'd7;
      default:             return 3'd7;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    last    = '{default: '0};
    m_seq   = '0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // Compare current outputs to the model, advance the model by this cycle's inputs, then clock.
  task automatic tick();
    rec_t r;
    rec_t n;
    r = (q.size() > 0) ? q[0] : last;
    check_eq("valid", trc_valid, q.size() > 0);
    check_eq("pc", trc_pc, r.pc);
    check_eq("instr", trc_instr, r.instr);
    check_eq("class", trc_class, r.cls);
    check_eq("rd_addr", trc_rd_addr, r.rd);
    check_eq("rd_wdata", trc_rd_wdata, r.wd);
    check_eq("seq", trc_seq, r.seq);
    check_eq("overflow", overflow, m_ovf);
    check_eq("drop_cnt", drop_cnt, m_drops);
    if (rst) begin
      model_reset();
    end else begin
      if (q.size() > 0 && trc_ready) last = q.pop_front();
      if (clr) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      if (retire_valid) begin
        if (q.size() < DEPTH) begin
          n.pc    = retire_pc;
          n.instr = retire_instr;
          n.cls   = ref_class(retire_instr);
          n.rd    = retire_rd_we ? retire_rd_addr : 5'd0;
          n.wd    = retire_rd_we ? retire_rd_wdata : 32'd0;
          n.seq   = m_seq;
          q.push_back(n);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
        m_seq = m_seq + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] i, input logic we,
                        input logic [4:0] a, input logic [31:0] d);
    retire_valid    = 1'b1;
    retire_pc       = p;
    retire_instr    = i;
    retire_rd_we    = we;
    retire_rd_addr  = a;
    retire_rd_wdata = d;
  endtask

  task automatic retire_rand();
    retire($urandom, $urandom, 1'($urandom), 5'($urandom), $urandom);
  endtask

  task automatic do_reset();
    retire_valid = 1'b0;
    clr          = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] tbl_instr [7] = '{32'h02B54533, 32'h00B50463, 32'h000500E7, 32'h00052503,
                                 32'h00A52023, 32'h30051073, 32'h30200073};
  logic [2:0]  tbl_cls   [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] pool      [10] = '{32'h00B50533, 32'h02B54533, 32'h00B50463, 32'h000500E7,
                                  32'h00052503, 32'h00A52023, 32'h30051073, 32'h30200073,
                                  32'h12345037, 32'h0000006F};

  initial begin
    rst = 1'b1; retire_valid = 1'b0; clr = 1'b0; trc_ready = 1'b0;
    retire_pc = '0; retire_instr = '0; retire_rd_we = 1'b0; retire_rd_addr = '0; retire_rd_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state, then an ADD visible one cycle later.
    check_eq("reset_valid", trc_valid, 1'b0);
    check_eq("reset_pc", trc_pc, 32'd0);
    check_eq("reset_drop", drop_cnt, 16'd0);
    trc_ready = 1'b1;
    retire(32'h80, 32'h00B50533, 1'b1, 5'd10, 32'd5);
    tick();
    retire_valid = 1'b0;
    check_eq("add_valid", trc_valid, 1'b1);
    check_eq("add_class", trc_class, 3'd0);
    check_eq("add_rd", trc_rd_addr, 5'd10);
    check_eq("add_wdata", trc_rd_wdata, 32'd5);
    check_eq("add_seq", trc_seq, 16'd0);
    tick();

    // Class table, back-to-back with ready held high.
    do_reset();
    trc_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      retire(32'h100 + 32'(i * 4), tbl_instr[i], (i != 4), 5'd7, 32'hDEAD);
      tick();
      check_eq("tbl_class", trc_class, tbl_cls[i]);
      check_eq("tbl_seq", trc_seq, 16'(i));
      if (i == 4) begin
        check_eq("sw_rd", trc_rd_addr, 5'd0);
        check_eq("sw_wdata", trc_rd_wdata, 32'd0);
      end
    end
    retire_valid = 1'b0;
    tick();

    // Six retires into a stalled consumer.
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin retire_rand(); tick(); end
    retire_valid = 1'b0;
    check_eq("ovf_set", overflow, 1'b1);
    check_eq("drop_two", drop_cnt, 16'd2);
    trc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_valid", trc_valid, 1'b1);
      check_eq("drain_seq", trc_seq, 16'(k));
      tick();
    end
    check_eq("drain_empty", trc_valid, 1'b0);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin retire_rand(); tick(); end
    trc_ready = 1'b1;
    retire_rand();
    tick();
    retire_valid = 1'b0;
    check_eq("full_pp_drop", drop_cnt, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      check_eq("full_pp_seq", trc_seq, 16'(k));
      tick();
    end
    check_eq("full_pp_empty", trc_valid, 1'b0);

    // Clear coincident with a drop, then clear alone.
    trc_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin retire_rand(); tick(); end
    check_eq("pre_clr_drop", drop_cnt, 16'd2);
    clr = 1'b1;
    retire_rand();
    tick();
    retire_valid = 1'b0;
    check_eq("clr_drop_ovf", overflow, 1'b1);
    check_eq("clr_drop_cnt", drop_cnt, 16'd1);
    tick();
    clr = 1'b0;
    check_eq("clr_ovf", overflow, 1'b0);
    check_eq("clr_cnt", drop_cnt, 16'd0);
    tick();

    // Drop counter saturation and sequence wrap.
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < 65532; i++) begin retire_rand(); tick(); end
    trc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin retire_rand(); tick(); end
    trc_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin retire_rand(); tick(); end
    retire_valid = 1'b0;
    check_eq("sat_drop", drop_cnt, 16'hFFFF);
    check_eq("wrap_seq0", trc_seq, 16'd0);
    trc_ready = 1'b1;
    tick();
    check_eq("wrap_seq1", trc_seq, 16'd1);
    for (int i = 0; i < 4; i++) tick();

    // Reset with records buffered.
    trc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin retire_rand(); tick(); end
    retire_valid = 1'b0;
    check_eq("pre_rst_valid", trc_valid, 1'b1);
    do_reset();
    check_eq("rst_mid_valid", trc_valid, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 70) begin
        retire_rand();
        if ($urandom_range(1) == 0) retire_instr = pool[$urandom_range(9)];
      end else begin
        retire_valid = 1'b0;
      end
      trc_ready = ($urandom_range(99) < 45);
      clr       = ($urandom_range(99) < 3);
      rst       = ($urandom_range(999) < 3);
      tick();
    end
    rst = 1'b0; clr = 1'b0; retire_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zeroriscy_trace_capture.md
Name: zeroriscy_trace_capture

Overview:
- Sits between the core's writeback/retire point and the instruction tracer/trace port.
- Samples every retired instruction, classifies it against the tracer instruction masks, tags it with a sequence number and buffers it in a small FIFO.
- Presents records to a consumer over a valid/ready handshake, so trace back-pressure never stalls the core.
- Overflow is reported as dropped records, never as a stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SEQ_W, 16, width of the sequence and drop counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- retire_valid_i  in  1  one instruction retires this cycle.
- retire_pc_i  in  32  PC of the retiring instruction.
- retire_instr_i  in  32  uncompressed instruction word.
- retire_rd_we_i  in  1  retiring instruction writes rd.
- retire_rd_addr_i  in  5  destination register.
- retire_rd_wdata_i  in  32  value written to rd.
- trc_valid_o  out  1  record available.
- trc_ready_i  in  1  consumer accepts record.
- trc_pc_o  out  32  record PC.
- trc_instr_o  out  32  record instruction.
- trc_class_o  out  3  instruction class (trc_class_e).
- trc_rd_addr_o  out  5  rd; 0 if no write.
- trc_rd_wdata_o  out  32  rd data; 0 if no write.
- trc_seq_o  out  SEQ_W  sequence number of record.
- overflow_o  out  1  sticky: at least one record dropped.
- drop_cnt_o  out  SEQ_W  saturating count of dropped records.
- clr_i  in  1  clears overflow_o and drop_cnt_o.

Behaviour:
- Reset: FIFO empty, trc_valid_o=0, all trc_* data outputs 0, overflow_o=0, drop_cnt_o=0, sequence counter 0. Reset is effective mid-transfer; any buffered records are discarded.
- Classification is combinational on retire_instr_i, priority-matched against the package masks:
  - MULDIV (1): DIV/DIVU/REM/REMU/PMUL*. Checked before ALU.
  - ALU (0): OP, OPIMM, LUI, AUIPC.
  - BRANCH (2)
  - JUMP (3): JAL, JALR.
  - LOAD (4)
  - STORE (5)
  - CSR (6): CSRR*.
  - SYS_OTHER (7): ECALL/EBREAK/MRET/WFI and any unmatched encoding.
- Record write: when retire_valid_i=1 and the FIFO accepts it, the record is written with rd fields masked to 0 if retire_rd_we_i=0, and seq = current sequence counter.
- Sequence counter increments on every retire_valid_i, including dropped records, and wraps modulo 2^SEQ_W. A gap in trc_seq_o identifies drops.
- Latency: a record accepted in cycle N is visible at trc_valid_o in N+1 (registered, no fall-through). Empty FIFO: trc_valid_o=0 and data outputs hold their last value.
- Handshake: a pop occurs when trc_valid_o && trc_ready_i. While trc_valid_o=1 and trc_ready_i=0, the outputs are stable.
- Push acceptance: accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle (slot is freed the same cycle).
- Simultaneous push+pop with count between 1 and DEPTH: count unchanged; order is preserved.
- Full with no pop: the record is dropped. overflow_o<=1; drop_cnt_o increments, saturating at all-ones.
- clr_i: overflow_o<=0 and drop_cnt_o<=0 next cycle. If a drop occurs in the same cycle, clear applies first: overflow_o<=1, drop_cnt_o<=1.
- clr_i does not affect FIFO contents or the sequence counter.
- Pointers wrap modulo DEPTH. Occupancy is tracked by a ($clog2(DEPTH)+1)-bit counter.

Decomposition:
- zeroriscy_tracer_defines (package):
  - add trc_class_e (3-bit enum, values above);
  - add trace_rec_t struct {pc, instr, class, rd_addr, rd_wdata, seq};
  - add INSTR_LOAD and INSTR_STORE masks;
  - reuse the existing INSTR_* masks for classification.
- Sub-module zeroriscy_trace_fifo: generic synchronous FIFO of trace_rec_t with push/pop/full/empty and count. The capture block holds classification, the sequence counter and overflow logic.

Test Plan:
- Reset, then retire ADD (0x00B50533, pc 0x80) with rd_we=1, rd=10, wdata=5; hold trc_ready_i=1 -> next cycle trc_valid_o=1, class=0, rd=10, wdata=5, seq=0; no stall.
- Retire DIV 0x02B54533, BEQ 0x00B50463, JALR 0x000500E7, LW 0x00052503, SW 0x00A52023, CSRRW 0x30051073, MRET 0x30200073 -> classes 1,2,3,4,5,6,7 in order; seq 0..6. SW with rd_we=0 -> rd/wdata outputs 0.
- trc_ready_i=0, DEPTH=4, 6 back-to-back retires -> first 4 buffered; overflow_o=1, drop_cnt_o=2. After releasing ready, the consumer sees seq 0,1,2,3 then no valid.
- FIFO full, trc_ready_i=1 and retire in the same cycle -> no drop, count stays 4, new record appears after the 3 older ones.
- clr_i asserted coincident with a drop -> overflow_o=1, drop_cnt_o=1; clr_i alone next cycle -> both 0.
- Hold 0xFFFF+3 drops -> drop_cnt_o saturates at 0xFFFF. Sequence wraps from 0xFFFF to 0 without error. Reset asserted with 3 records buffered -> trc_valid_o=0 next cycle.
